sequenciador_ativos: RTL
========================

// Module: sequenciador_ativos
// PURPOSE
//  Controller in front of the active-node evaluator (avaliador_ativos) of the path-search datapath.
//  - Accepts a stream of update/deactivate requests.
//  - Issues each request as a single-cycle command, then waits for the evaluator's ready (pronto) flag.
//  - On a batch-close request, drains every approved node one at a time through a valid/ready port.
//  - Then pulses remover_aprovados.
// PARAMETERS
//  NUM_NA          4   number of active-node slots in the evaluator
//  ADDR_WIDTH      5   node address width
//  DISTANCIA_WIDTH 5   distance width
//  CUSTO_WIDTH     4   neighbour-cost width
//  TIMEOUT_WIDTH   8   watchdog counter width; limit = 2**TIMEOUT_WIDTH-1 cycles
// PORTS
//  clk                     in   1                  clock, rising edge
//  rst_n                   in   1                  asynchronous reset, active low
//  req_valid_in            in   1                  request valid
//  req_desativar_in        in   1                  1=deactivate endereco, 0=update
//  req_endereco_in         in   ADDR_WIDTH         node address
//  req_anterior_in         in   ADDR_WIDTH         predecessor address
//  req_distancia_in        in   DISTANCIA_WIDTH    distance
//  req_menor_vizinho_in    in   CUSTO_WIDTH        smallest neighbour cost
//  req_ready_out           out  1                  request accepted when valid&ready
//  fechar_lote_in          in   1                  pulse: drain approved nodes after pending work
//  sa_atualizar_out        out  1                  evaluator atualizar_in, 1-cycle pulse
//  sa_desativar_out        out  1                  evaluator desativar_in, 1-cycle pulse
//  sa_endereco_out         out  ADDR_WIDTH         evaluator endereco_in
//  sa_anterior_out         out  ADDR_WIDTH         evaluator anterior_in
//  sa_distancia_out        out  DISTANCIA_WIDTH    evaluator distancia_in
//  sa_menor_vizinho_out    out  CUSTO_WIDTH        evaluator menor_vizinho_in
//  sa_remover_aprovados_out out 1                  evaluator remover_aprovados_in, 1-cycle pulse
//  aa_ocupado_in           in   1                  evaluator busy
//  aa_pronto_in            in   1                  evaluator classification done
//  aa_aprovado_in          in   NUM_NA             per-slot approved flags
//  aa_endereco_in          in   ADDR_WIDTH*NUM_NA  slot addresses, slot i at [ADDR_WIDTH*i +: ADDR_WIDTH]
//  aa_distancia_in         in   DISTANCIA_WIDTH*NUM_NA  slot distances, same packing
//  ap_valid_out            out  1                  approved node valid
//  ap_endereco_out         out  ADDR_WIDTH         approved node address
//  ap_distancia_out        out  DISTANCIA_WIDTH    approved node distance
//  ap_ready_in             in   1                  consumer ready
//  sa_lote_concluido_out   out  1                  1-cycle pulse when the batch drain is finished
//  sa_erro_out             out  1                  sticky watchdog error; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0; FSM=OCIOSO; command registers, sent-mask and watchdog cleared.
//   Reset mid-operation aborts immediately; no remover pulse is issued.
//  States: OCIOSO, EMITIR, ESPERA_INICIO, ESPERA_PRONTO, DRENAR, REMOVER, FIM.
//  OCIOSO: req_ready_out=1.
//   - valid&ready: latch request, go EMITIR.
//   - else if lote_pendente, go DRENAR.
//  lote_pendente: set by fechar_lote_in in any state; cleared on entering DRENAR.
//  EMITIR: sa_* data stable from the latch cycle.
//   - aa_ocupado_in=0: assert atualizar (or desativar) for exactly 1 cycle, go ESPERA_INICIO.
//   - aa_ocupado_in=1: hold the pulse low and stay.
//  ESPERA_INICIO: 1 cycle; aa_pronto_in is ignored here (evaluator clears pronto a cycle late). Go ESPERA_PRONTO.
//  ESPERA_PRONTO: aa_pronto_in=1 -> OCIOSO. A new request is accepted no earlier than the following cycle.
//  DRENAR:
//   - pend = aa_aprovado_in & ~mask_enviado.
//   - ap_valid_out=|pend, presenting the lowest pend index: slot address and distance.
//   - Output data is held while valid&~ready.
//   - Handshake sets that slot's mask bit.
//   - pend==0 (including zero approved): go REMOVER.
//  REMOVER: sa_remover_aprovados_out=1 for 1 cycle; clear mask; go FIM.
//  FIM: sa_lote_concluido_out=1 for 1 cycle; go OCIOSO.
//  Watchdog:
//   - Counts cycles in EMITIR/ESPERA_PRONTO; cleared on state change.
//   - At the all-ones limit: set sa_erro_out, go OCIOSO.
//   - Saturates; never wraps.
//  Simultaneous fechar_lote_in with req_valid_in in OCIOSO: the request wins and the batch is remembered.
//  Requests arriving while the drain runs stall: req_ready_out=0 outside OCIOSO.
// TESTING
//  1. Update req addr=3,dist=7,cost=2; ocupado=0; pronto re-asserts 4 cycles later -> exactly one atualizar pulse; fields 3/7/2; ready again 1 cycle after pronto.
//  2. Deactivate req with ocupado=1 for 5 cycles -> desativar held low 5 cycles, then a single pulse; pronto (still 1) during ESPERA_INICIO is ignored.
//  3. aprovado=4'b1010, addr slot1=6, slot3=9; ap_ready toggled 1/0 -> outputs 6 then 9 with stable data; one remover pulse; then lote_concluido.
//  4. fechar_lote with aprovado=0 -> no ap_valid; REMOVER then FIM pulses within 3 cycles.
//  5. pronto never returns, TIMEOUT_WIDTH=4 -> sa_erro_out=1 after 15 cycles; FSM OCIOSO; erro stays set until rst_n.
//  6. rst_n low during DRENAR -> all outputs 0 asynchronously; no remover pulse; mask cleared.

Source files
------------

// File: rtl/sequenciador_ativos.sv
// sequenciador_ativos: request sequencer and approved-node drain controller sitting in front
// of the active-node evaluator (avaliador_ativos). Issues one command at a time, waits for the
// evaluator to finish, and on batch close streams every approved slot out before asking the
// evaluator to remove them.
module sequenciador_ativos #(
    parameter int unsigned NUM_NA          = 4,
    parameter int unsigned ADDR_WIDTH      = 5,
    parameter int unsigned DISTANCIA_WIDTH = 5,
    parameter int unsigned CUSTO_WIDTH     = 4,
    parameter int unsigned TIMEOUT_WIDTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid_in,
    input  logic                              req_desativar_in,
    input  logic [ADDR_WIDTH-1:0]             req_endereco_in,
    input  logic [ADDR_WIDTH-1:0]             req_anterior_in,
    input  logic [DISTANCIA_WIDTH-1:0]        req_distancia_in,
    input  logic [CUSTO_WIDTH-1:0]            req_menor_vizinho_in,
    output logic                              req_ready_out,
    input  logic                              fechar_lote_in,
    output logic                              sa_atualizar_out,
    output logic                              sa_desativar_out,
    output logic [ADDR_WIDTH-1:0]             sa_endereco_out,
    output logic [ADDR_WIDTH-1:0]             sa_anterior_out,
    output logic [DISTANCIA_WIDTH-1:0]        sa_distancia_out,
    output logic [CUSTO_WIDTH-1:0]            sa_menor_vizinho_out,
    output logic                              sa_remover_aprovados_out,
    input  logic                              aa_ocupado_in,
    input  logic                              aa_pronto_in,
    input  logic [NUM_NA-1:0]                 aa_aprovado_in,
    input  logic [ADDR_WIDTH*NUM_NA-1:0]      aa_endereco_in,
    input  logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_in,
    output logic                              ap_valid_out,
    output logic [ADDR_WIDTH-1:0]             ap_endereco_out,
    output logic [DISTANCIA_WIDTH-1:0]        ap_distancia_out,
    input  logic                              ap_ready_in,
    output logic                              sa_lote_concluido_out,
    output logic                              sa_erro_out
);

    localparam int unsigned IDX_W = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;
    // Timeout fires on the last waiting cycle so the error lands after 2**W-1 cycles in state.
    localparam logic [TIMEOUT_WIDTH-1:0] WD_MAX = {TIMEOUT_WIDTH{1'b1}};
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LIM = WD_MAX - 1'b1;

    typedef enum logic [2:0] {
        StOcioso,
        StEmitir,
        StEsperaInicio,
        StEsperaPronto,
        StDrenar,
        StRemover,
        StFim
    } estado_e;

    estado_e                      state_q, state_d;
    logic                         desativar_q, desativar_d;
    logic [ADDR_WIDTH-1:0]        endereco_q, endereco_d;
    logic [ADDR_WIDTH-1:0]        anterior_q, anterior_d;
    logic [DISTANCIA_WIDTH-1:0]   distancia_q, distancia_d;
    logic [CUSTO_WIDTH-1:0]       menor_vizinho_q, menor_vizinho_d;
    logic [NUM_NA-1:0]            mask_q, mask_d;
    logic [TIMEOUT_WIDTH-1:0]     wd_q, wd_d;
    logic                         erro_q, erro_d;
    logic                         lote_q, lote_d;
    logic                         hold_q, hold_d;
    logic [IDX_W-1:0]             sel_q, sel_d;

    logic [NUM_NA-1:0]            pend;
    logic [IDX_W-1:0]             sel_low;
    logic [IDX_W-1:0]             sel;
    logic [ADDR_WIDTH-1:0]        slot_endereco;
    logic [DISTANCIA_WIDTH-1:0]   slot_distancia;
    logic                         aceita;
    logic                         handshake;
    logic                         esperando;
    logic                         estouro;

    // Pending approved slots, lowest-index pick and the slot data it selects.
    always_comb begin
        pend    = aa_aprovado_in & ~mask_q;
        sel_low = '0;
        for (int i = int'(NUM_NA) - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_low = IDX_W'(i);
            end
        end
        // A stalled offer keeps its slot even if a lower one becomes pending meanwhile.
        sel            = hold_q ? sel_q : sel_low;
        slot_endereco  = '0;
        slot_distancia = '0;
        for (int i = 0; i < int'(NUM_NA); i++) begin
            if (IDX_W'(i) == sel) begin
                slot_endereco  = aa_endereco_in[ADDR_WIDTH*i +: ADDR_WIDTH];
                slot_distancia = aa_distancia_in[DISTANCIA_WIDTH*i +: DISTANCIA_WIDTH];
            end
        end
    end

    // Outputs decoded from the current state and the command registers.
    always_comb begin
        req_ready_out            = (state_q == StOcioso) && rst_n;
        sa_atualizar_out         = (state_q == StEmitir) && !aa_ocupado_in && !desativar_q;
        sa_desativar_out         = (state_q == StEmitir) && !aa_ocupado_in && desativar_q;
        sa_endereco_out          = endereco_q;
        sa_anterior_out          = anterior_q;
        sa_distancia_out         = distancia_q;
        sa_menor_vizinho_out     = menor_vizinho_q;
        sa_remover_aprovados_out = (state_q == StRemover);
        sa_lote_concluido_out    = (state_q == StFim);
        sa_erro_out              = erro_q;
        ap_valid_out             = (state_q == StDrenar) && (hold_q || (|pend));
        ap_endereco_out          = ap_valid_out ? slot_endereco : '0;
        ap_distancia_out         = ap_valid_out ? slot_distancia : '0;
    end

    assign aceita    = req_valid_in && req_ready_out;
    assign handshake = ap_valid_out && ap_ready_in;
    assign esperando = (state_q == StEmitir) || (state_q == StEsperaPronto);
    // Watchdog only trips when the state would otherwise stay put.
    assign estouro   = (wd_q == WD_LIM) &&
                       (((state_q == StEmitir) && aa_ocupado_in) ||
                        ((state_q == StEsperaPronto) && !aa_pronto_in));

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StOcioso: begin
                if (aceita) begin
                    state_d = StEmitir;
                end else if (lote_q || fechar_lote_in) begin
                    state_d = StDrenar;
                end
            end
            StEmitir: begin
                if (!aa_ocupado_in) begin
                    state_d = StEsperaInicio;
                end else if (estouro) begin
                    state_d = StOcioso;
                end
            end
            // Evaluator still shows the previous pronto here, so it is not looked at.
            StEsperaInicio: state_d = StEsperaPronto;
            StEsperaPronto: begin
                if (aa_pronto_in || estouro) begin
                    state_d = StOcioso;
                end
            end
            StDrenar: begin
                if (!ap_valid_out) begin
                    state_d = StRemover;
                end
            end
            StRemover: state_d = StFim;
            StFim:     state_d = StOcioso;
            default:   state_d = StOcioso;
        endcase
    end

    // Command latch, sent-mask, stalled-offer hold, batch flag, watchdog and error flag.
    always_comb begin
        desativar_d     = desativar_q;
        endereco_d      = endereco_q;
        anterior_d      = anterior_q;
        distancia_d     = distancia_q;
        menor_vizinho_d = menor_vizinho_q;
        mask_d          = mask_q;
        hold_d          = hold_q;
        sel_d           = sel_q;
        erro_d          = erro_q || estouro;
        lote_d          = lote_q || fechar_lote_in;
        wd_d            = wd_q;

        if (aceita) begin
            desativar_d     = req_desativar_in;
            endereco_d      = req_endereco_in;
            anterior_d      = req_anterior_in;
            distancia_d     = req_distancia_in;
            menor_vizinho_d = req_menor_vizinho_in;
        end

        if ((state_q == StOcioso) && (state_d == StDrenar)) begin
            lote_d = 1'b0;
        end

        if (handshake) begin
            mask_d[sel] = 1'b1;
            hold_d      = 1'b0;
        end else if (ap_valid_out) begin
            hold_d = 1'b1;
            sel_d  = sel;
        end

        if (state_q == StRemover) begin
            mask_d = '0;
        end

        if (state_d != state_q) begin
            wd_d = '0;
        end else if (esperando && (wd_q != WD_MAX)) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // State and register update with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StOcioso;
            desativar_q     <= 1'b0;
            endereco_q      <= '0;
            anterior_q      <= '0;
            distancia_q     <= '0;
            menor_vizinho_q <= '0;
            mask_q          <= '0;
            wd_q            <= '0;
            erro_q          <= 1'b0;
            lote_q          <= 1'b0;
            hold_q          <= 1'b0;
            sel_q           <= '0;
        end else begin
            state_q         <= state_d;
            desativar_q     <= desativar_d;
            endereco_q      <= endereco_d;
            anterior_q      <= anterior_d;
            distancia_q     <= distancia_d;
            menor_vizinho_q <= menor_vizinho_d;
            mask_q          <= mask_d;
            wd_q            <= wd_d;
            erro_q          <= erro_d;
            lote_q          <= lote_d;
            hold_q          <= hold_d;
            sel_q           <= sel_d;
        end
    end

endmodule
